axi4_lite_ctrl_arbiter: RTL and testbench

//   Shares one AXI4-lite master control port among NUM_REQ requesters.

---
 rtl/axi4_lite_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 24 ++
 rtl/axi4_lite_ctrl_arbiter.sv | 104 ++++++++++
 tb/tb_axi4_lite_ctrl_arbiter.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_pkg.sv
// axi4_lite_pkg: AXI response codes and control-arbiter state encoding
package axi4_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP, ST_DRAIN} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at ptr, one-hot grant plus index
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx
);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    int off;
    int sum;
    assign dbl = {req, req};
    assign rot = dbl[ptr +: NUM_REQ];
    always_comb begin
        off = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) off = rot[i] ? i : off;
        sum = int'(ptr) + off;
        idx = IW'(sum >= NUM_REQ ? sum - NUM_REQ : sum);
        grant = NUM_REQ'(|req) << idx;
    end
endmodule

// File: rtl/axi4_lite_ctrl_arbiter.sv
// axi4_lite_ctrl_arbiter: round-robin sharing of one AXI4-lite control master with watchdog
module axi4_lite_ctrl_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                              ACLK,
    input  logic                              ARESETn,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]             rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              busy,
    output logic [ADDRESS_WIDTH-1:0]          ctrl_addr,
    output logic [DATA_WIDTH-1:0]             ctrl_wdata,
    output logic                              ctrl_write_en,
    output logic                              ctrl_read_en,
    input  logic [DATA_WIDTH-1:0]             ctrl_rdata,
    input  logic [1:0]                        ctrl_resp,
    input  logic                              ctrl_done
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    arb_state_e state, state_nxt;
    logic [IW-1:0]            ptr, gnt_idx, g_idx;
    logic [NUM_REQ-1:0]       gnt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q, rdata_q;
    logic [1:0]               resp_q;
    logic                     write_q, drain_q, accept, timeout;
    logic [CW-1:0]            wd_cnt;
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx)
    );
    assign accept        = state == ST_IDLE && |req_valid;
    assign timeout       = TIMEOUT_CYCLES != 0 && int'(wd_cnt) == TIMEOUT_CYCLES - 1;
    assign req_ready     = state == ST_IDLE ? gnt : '0;
    assign rsp_valid     = state == ST_RESP ? NUM_REQ'(1) << g_idx : '0;
    assign busy          = state != ST_IDLE;
    assign ctrl_write_en = state == ST_ISSUE && write_q;
    assign ctrl_read_en  = state == ST_ISSUE && !write_q;
    assign ctrl_addr     = addr_q;
    assign ctrl_wdata    = wdata_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= ST_IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  state_nxt = accept ? ST_ISSUE : ST_IDLE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  state_nxt = ctrl_done || timeout ? ST_RESP : ST_WAIT;
            ST_RESP:  state_nxt = drain_q ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: state_nxt = ctrl_done ? ST_IDLE : ST_DRAIN;
            default:  state_nxt = ST_IDLE;
        endcase
    end
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr     <= '0;
            g_idx   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            drain_q <= 1'b0;
            wd_cnt  <= '0;
        end else begin
            if (accept) begin
                g_idx   <= gnt_idx;
                ptr     <= int'(gnt_idx) == NUM_REQ - 1 ? '0 : gnt_idx + 1'b1;
                addr_q  <= req_addr[gnt_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                wdata_q <= req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                write_q <= req_write[gnt_idx];
            end
            if (state == ST_ISSUE) wd_cnt <= '0;
            else if (state == ST_WAIT && int'(wd_cnt) < TIMEOUT_CYCLES) wd_cnt <= wd_cnt + 1'b1;
            // a real done wins over a simultaneous watchdog expiry
            if (state == ST_WAIT && ctrl_done) begin
                rdata_q <= write_q ? '0 : ctrl_rdata;
                resp_q  <= ctrl_resp;
            end else if (state == ST_WAIT && timeout) begin
                rdata_q <= '0;
                resp_q  <= RESP_SLVERR;
                drain_q <= 1'b1;
            end
            if (state == ST_DRAIN && ctrl_done) drain_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi4_lite_ctrl_arbiter.sv
// tb_axi4_lite_ctrl_arbiter: directed self-checking bench for axi4_lite_ctrl_arbiter
module tb_axi4_lite_ctrl_arbiter;
    logic         ACLK = 1'b0;
    logic         ARESETn = 1'b0;
    logic [3:0]   req_valid = '0;
    logic [3:0]   req_write = '0;
    logic [127:0] req_addr = '0;
    logic [127:0] req_wdata = '0;
    logic [3:0]   req_ready, rsp_valid;
    logic [31:0]  rsp_rdata, ctrl_addr, ctrl_wdata;
    logic [1:0]   rsp_resp;
    logic         busy, ctrl_write_en, ctrl_read_en;
    logic [31:0]  ctrl_rdata = '0;
    logic [1:0]   ctrl_resp = '0;
    logic         ctrl_done = 1'b0;
    int checks = 0;
    int errors = 0;
    axi4_lite_ctrl_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .ADDRESS_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .busy          (busy),
        .ctrl_addr     (ctrl_addr),
        .ctrl_wdata    (ctrl_wdata),
        .ctrl_write_en (ctrl_write_en),
        .ctrl_read_en  (ctrl_read_en),
        .ctrl_rdata    (ctrl_rdata),
        .ctrl_resp     (ctrl_resp),
        .ctrl_done     (ctrl_done)
    );
    always #5 ACLK = ~ACLK;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    // called on a falling edge while idle; dly = WAIT cycles before done
    task automatic run_txn(input int r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input int dly, input logic [31:0] rd, input logic [1:0] rs,
                           input logic [31:0] exp_rd);
        req_valid = 4'(1 << r);
        req_write[r] = w;
        req_addr[r*32 +: 32] = a;
        req_wdata[r*32 +: 32] = wd;
        #1 check("ready", 64'(req_ready), 64'(1 << r));
        @(negedge ACLK);
        req_valid = '0;
        check("wr_strobe", 64'(ctrl_write_en), 64'(w));
        check("rd_strobe", 64'(ctrl_read_en), 64'(!w));
        check("addr", 64'(ctrl_addr), 64'(a));
        check("wdata", 64'(ctrl_wdata), 64'(wd));
        for (int i = 0; i < dly; i++) begin
            @(negedge ACLK);
            check("strobe_once", 64'(ctrl_write_en | ctrl_read_en), 64'(0));
            check("wait_no_rsp", 64'(rsp_valid), 64'(0));
        end
        ctrl_done = 1'b1;
        ctrl_rdata = rd;
        ctrl_resp = rs;
        @(negedge ACLK);
        ctrl_done = 1'b0;
        check("rsp_valid", 64'(rsp_valid), 64'(1 << r));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_resp", 64'(rsp_resp), 64'(rs));
        @(negedge ACLK);
        check("rsp_pulse", 64'(rsp_valid), 64'(0));
        check("idle", 64'(busy), 64'(0));
    endtask
    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end
    initial begin
        repeat (2) @(negedge ACLK);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_rsp", 64'(rsp_valid), 64'(0));
        check("rst_strobes", 64'({ctrl_write_en, ctrl_read_en}), 64'(0));
        check("rst_addr", 64'(ctrl_addr), 64'(0));
        ARESETn = 1'b1;
        @(negedge ACLK);
        run_txn(0, 1'b1, 32'h10, 32'hA5A5_A5A5, 3, 32'h1234_5678, 2'b00, 32'h0);
        run_txn(2, 1'b0, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, 2'b00, 32'hDEAD_BEEF);
        req_valid = 4'b0010;
        req_write[1] = 1'b0;
        req_addr[32 +: 32] = 32'h44;
        #1 check("to_ready", 64'(req_ready), 64'(4'b0010));
        @(negedge ACLK);
        req_valid = '0;
        check("to_issue", 64'(ctrl_read_en), 64'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge ACLK);
            check("to_wait", 64'({busy, rsp_valid}), 64'(5'b10000));
        end
        @(negedge ACLK);
        check("to_rsp", 64'(rsp_valid), 64'(4'b0010));
        check("to_resp", 64'(rsp_resp), 64'(2'b10));
        check("to_rdata", 64'(rsp_rdata), 64'(0));
        repeat (2) begin
            @(negedge ACLK);
            check("drain", 64'({busy, rsp_valid}), 64'(5'b10000));
        end
        ctrl_done = 1'b1;
        ctrl_rdata = 32'hBAD0_BAD0;
        @(negedge ACLK);
        ctrl_done = 1'b0;
        check("drain_done", 64'({busy, rsp_valid}), 64'(0));
        run_txn(0, 1'b1, 32'h30, 32'h0000_1111, 1, 32'h0, 2'b00, 32'h0);
        ctrl_done = 1'b1;
        ctrl_resp = 2'b10;
        @(negedge ACLK);
        ctrl_done = 1'b0;
        check("stray_rsp", 64'(rsp_valid), 64'(0));
        check("stray_busy", 64'(busy), 64'(0));
        req_valid = 4'b1000;
        req_write[3] = 1'b0;
        req_addr[96 +: 32] = 32'h88;
        #1 check("stray_ready", 64'(req_ready), 64'(4'b1000));
        @(negedge ACLK);
        req_valid = '0;
        @(negedge ACLK);
        ARESETn = 1'b0;
        #1 check("mid_rst_out", 64'({busy, rsp_valid, ctrl_write_en, ctrl_read_en}), 64'(0));
        check("mid_rst_addr", 64'(ctrl_addr), 64'(0));
        @(negedge ACLK);
        ARESETn = 1'b1;
        ctrl_done = 1'b1;
        @(negedge ACLK);
        ctrl_done = 1'b0;
        check("mid_rst_norsp", 64'(rsp_valid), 64'(0));
        for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = 32'h100 + 32'(i);
        req_write = '0;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1 check("rr_ready", 64'(req_ready), 64'(1 << (k % 4)));
            @(negedge ACLK);
            check("rr_addr", 64'(ctrl_addr), 64'(32'h100 + 32'(k % 4)));
            @(negedge ACLK);
            ctrl_done = 1'b1;
            ctrl_rdata = 32'(k);
            ctrl_resp = 2'b00;
            @(negedge ACLK);
            ctrl_done = 1'b0;
            check("rr_rsp", 64'(rsp_valid), 64'(1 << (k % 4)));
            check("rr_rdata", 64'(rsp_rdata), 64'(k));
            @(negedge ACLK);
        end
        req_valid = '0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
